// File: rtl/clock_period_meter.sv
// clock_period_meter
// Samples a slow divided clock in the clock_in domain, times the interval
// between its edges and reports lock / out-of-range / loss-of-clock status.

module clock_period_meter #(
    parameter int CNT_WIDTH     = 14,
    parameter int EXPECTED_HALF = 4095,
    parameter int TOLERANCE     = 2,
    parameter int LOCK_COUNT    = 4,
    parameter int TIMEOUT       = 12285
) (
    input  logic                 clock_in,
    input  logic                 reset,
    input  logic                 sig_in,
    output logic                 edge_pulse,
    output logic [CNT_WIDTH-1:0] half_period,
    output logic                 meas_valid,
    output logic                 in_range,
    output logic                 locked,
    output logic                 lost
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEASURE,
        ST_LOCKED,
        ST_LOST
    } state_t;

    localparam int GC_W = $clog2(LOCK_COUNT + 1);
    localparam int CW2  = CNT_WIDTH + 2;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT);
    localparam logic [GC_W-1:0]      LOCK_C    = GC_W'(LOCK_COUNT);
    localparam logic [CW2-1:0]       EXP_W     = CW2'(EXPECTED_HALF);
    localparam logic [CW2-1:0]       TOL_W     = CW2'(TOLERANCE);

    logic                 s1, s2, s3;
    logic                 edge_det;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] meas;
    logic [CW2-1:0]       meas_w;
    logic                 meas_in_range;
    logic [GC_W-1:0]      good_count;
    logic [GC_W-1:0]      gc_inc;
    logic                 measuring;
    logic                 timeout_hit;
    state_t               state;
    state_t               state_next;

    // Edge seen between the 2nd and 3rd synchronizer stages
    assign edge_det = s2 ^ s3;

    // Interval to the current edge is the saturating successor of cnt
    assign meas   = (cnt == CNT_MAX) ? CNT_MAX : cnt + 1'b1;
    assign meas_w = CW2'(meas);

    // Window check done in a widened domain so EXPECTED_HALF-TOLERANCE cannot underflow
    assign meas_in_range = (meas_w + TOL_W >= EXP_W) && (meas_w <= EXP_W + TOL_W);

    assign gc_inc      = good_count + 1'b1;
    assign measuring   = (state == ST_MEASURE) || (state == ST_LOCKED);
    assign timeout_hit = measuring && (meas >= TIMEOUT_C);

    // Three-flop synchronizer and registered edge pulse
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            s3         <= 1'b0;
            edge_pulse <= 1'b0;
        end else begin
            s1         <= sig_in;
            s2         <= s1;
            s3         <= s2;
            edge_pulse <= edge_det;
        end
    end

    // Saturating cycle counter, restarted by every detected edge
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (edge_det) begin
            cnt <= '0;
        end else begin
            cnt <= meas;
        end
    end

    // Measurement capture: only edges that close a valid interval update the result
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            half_period <= '0;
            meas_valid  <= 1'b0;
            in_range    <= 1'b0;
        end else begin
            meas_valid <= edge_det && measuring;
            if (edge_det && measuring) begin
                half_period <= meas;
                in_range    <= meas_in_range;
            end
        end
    end

    // Run length of consecutive in-range measurements
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            good_count <= '0;
        end else if (edge_det) begin
            if (measuring && meas_in_range) begin
                if (good_count < LOCK_C) begin
                    good_count <= gc_inc;
                end
            end else begin
                good_count <= '0;
            end
        end
    end

    // State register
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: an edge in the timeout cycle takes priority over the timeout
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (edge_det) begin
                    state_next = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (edge_det) begin
                    if (meas_in_range && (gc_inc >= LOCK_C)) begin
                        state_next = ST_LOCKED;
                    end
                end else if (timeout_hit) begin
                    state_next = ST_LOST;
                end
            end
            ST_LOCKED: begin
                if (edge_det) begin
                    if (!meas_in_range) begin
                        state_next = ST_MEASURE;
                    end
                end else if (timeout_hit) begin
                    state_next = ST_LOST;
                end
            end
            ST_LOST: begin
                if (edge_det) begin
                    state_next = ST_MEASURE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Status outputs decoded from the registered state
    always_comb begin
        locked = (state == ST_LOCKED);
        lost   = (state == ST_LOST);
    end

endmodule

// File: tb/tb_clock_period_meter.sv
// Testbench for clock_period_meter: directed scenario sequence with randomized
// intervals, compared every cycle against a behavioural edge/interval model.

module tb_clock_period_meter;

    localparam int CNT_WIDTH     = 14;
    localparam int EXPECTED_HALF = 4095;
    localparam int TOLERANCE     = 2;
    localparam int LOCK_COUNT    = 4;
    localparam int TIMEOUT       = 12285;
    localparam int SAT           = (1 << CNT_WIDTH) - 1;

    logic                 clk;
    logic                 rst;
    logic                 sig_in;
    logic                 edge_pulse;
    logic [CNT_WIDTH-1:0] half_period;
    logic                 meas_valid;
    logic                 in_range;
    logic                 locked;
    logic                 lost;

    int n_cmp;
    int n_bad;

    // Behavioural model state: cycle index, pending edge times, interval bookkeeping
    int  n;
    int  edge_q[$];
    bit  prev_samp;
    bit  has_start;
    int  last_edge;
    int  run;
    bit  m_ep, m_mv, m_ir, m_locked, m_lost;
    int  m_hp;

    clock_period_meter #(
        .CNT_WIDTH    (CNT_WIDTH),
        .EXPECTED_HALF(EXPECTED_HALF),
        .TOLERANCE    (TOLERANCE),
        .LOCK_COUNT   (LOCK_COUNT),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .clock_in   (clk),
        .reset      (rst),
        .sig_in     (sig_in),
        .edge_pulse (edge_pulse),
        .half_period(half_period),
        .meas_valid (meas_valid),
        .in_range   (in_range),
        .locked     (locked),
        .lost       (lost)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        n = 0;
        edge_q.delete();
        prev_samp = 1'b0;
        has_start = 1'b0;
        last_edge = 0;
        run       = 0;
        m_ep = 0; m_mv = 0; m_ir = 0; m_locked = 0; m_lost = 0;
        m_hp = 0;
    endtask

    // One clock of the model: a new sampled level shows up as edge_pulse two cycles later;
    // the interval between consecutive edges is the measurement.
    task automatic model_step();
        int iv;
        int dev;
        if (rst) begin
            model_reset();
            return;
        end
        n++;
        m_ep = 0;
        m_mv = 0;
        if (sig_in !== prev_samp) begin
            edge_q.push_back(n + 2);
            prev_samp = sig_in;
        end
        if (edge_q.size() > 0 && edge_q[0] == n) begin
            void'(edge_q.pop_front());
            m_ep = 1;
            if (!has_start || m_lost) begin
                has_start = 1;
                m_lost    = 0;
                run       = 0;
            end else begin
                iv = n - last_edge;
                if (iv > SAT) iv = SAT;
                dev  = (iv > EXPECTED_HALF) ? iv - EXPECTED_HALF : EXPECTED_HALF - iv;
                m_hp = iv;
                m_ir = (dev <= TOLERANCE);
                m_mv = 1;
                if (m_ir) begin
                    run++;
                    if (run >= LOCK_COUNT) m_locked = 1;
                end else begin
                    run      = 0;
                    m_locked = 0;
                end
            end
            last_edge = n;
        end else if (has_start && !m_lost && (n - last_edge == TIMEOUT)) begin
            m_lost   = 1;
            m_locked = 0;
            run      = 0;
        end
    endtask

    task automatic check_all();
        chk("edge_pulse",  32'(edge_pulse),  32'(m_ep));
        chk("meas_valid",  32'(meas_valid),  32'(m_mv));
        chk("half_period", 32'(half_period), 32'(m_hp));
        chk("in_range",    32'(in_range),    32'(m_ir));
        chk("locked",      32'(locked),      32'(m_locked));
        chk("lost",        32'(lost),        32'(m_lost));
    endtask

    task automatic tick(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            check_all();
        end
    endtask

    // Hold sig_in for h cycles, then toggle it (called at a falling clock edge)
    task automatic hold_toggle(input int h);
        tick(h);
        sig_in = ~sig_in;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_edge_pulse"},  32'(edge_pulse),  32'd0);
        chk({tag, "_meas_valid"},  32'(meas_valid),  32'd0);
        chk({tag, "_half_period"}, 32'(half_period), 32'd0);
        chk({tag, "_in_range"},    32'(in_range),    32'd0);
        chk({tag, "_locked"},      32'(locked),      32'd0);
        chk({tag, "_lost"},        32'(lost),        32'd0);
    endtask

    initial begin
        int w;
        n_cmp = 0;
        n_bad = 0;
        model_reset();

        // Reset with sig_in held high; release yields the IDLE first edge
        rst    = 1'b1;
        sig_in = 1'b1;
        #1;
        check_zero("reset");
        tick(3);
        rst = 1'b0;

        // Nominal toggling: lock on the 5th edge
        for (int k = 0; k < 4; k++) hold_toggle(EXPECTED_HALF);
        tick(3);
        chk("lock_nominal", 32'(locked), 32'd1);

        // Reset partway through a locked interval
        w = $urandom_range(1800, 2200);
        tick(w);
        rst = 1'b1;
        model_reset();
        #1;
        check_zero("reset_mid");
        @(negedge clk);
        tick(3);
        rst = 1'b0;

        // First edge (held level) free, then 4095, then out of range, then relock at 4097
        hold_toggle(EXPECTED_HALF);
        hold_toggle(EXPECTED_HALF + TOLERANCE + 1);
        for (int k = 0; k < 4; k++) hold_toggle(EXPECTED_HALF + TOLERANCE);
        tick(3);
        chk("post_reset_hp", 32'(half_period), 32'(EXPECTED_HALF + TOLERANCE));
        chk("lock_4097", 32'(locked), 32'd1);

        // Freeze sig_in: loss of clock after TIMEOUT cycles
        tick(TIMEOUT + 10);
        chk("lost_freeze", 32'(lost), 32'd1);
        chk("lost_unlocked", 32'(locked), 32'd0);

        // Resume: edge clears lost; the next edge lands exactly in the timeout cycle
        sig_in = ~sig_in;
        hold_toggle(TIMEOUT);
        tick(3);
        chk("edge_at_timeout_hp", 32'(half_period), 32'(TIMEOUT));
        chk("edge_at_timeout_ir", 32'(in_range), 32'd0);
        chk("edge_at_timeout_lost", 32'(lost), 32'd0);

        // Relock with randomized in-range intervals
        for (int k = 0; k < 4; k++) begin
            hold_toggle($urandom_range(EXPECTED_HALF - TOLERANCE, EXPECTED_HALF + TOLERANCE));
        end
        tick(5);
        chk("relock", 32'(locked), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
